ysyx_22050133_id_scoreboard: RTL and testbench
==============================================

YSYX_22050133_ID_SCOREBOARD -- requirements
Module: ysyx_22050133_id_scoreboard

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers tracked; index width RW = clog2(NREG).
REQ-002 Parameter CNT_W, default 2, per-register outstanding-writer counter width; CMAX = 2^CNT_W-1.
REQ-003 Parameter NWB, default 2, number of write-back/cancel release channels.
REQ-004 Parameter WB_BYPASS, default 1, 1 = a same-cycle release may clear the issue hazard.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 iss_valid  in  1  decoded instruction present at ID.
REQ-008 iss_rs1, iss_rs2  in  RW each  source register indices; 0 = unused.
REQ-009 iss_rd  in  RW  destination index; iss_rdwen  in  1  instruction writes rd.
REQ-010 iss_ready  out  1  no hazard; issue accepted when iss_valid & iss_ready (fire).
REQ-011 has_hazard  out  1  iss_valid & ~iss_ready; drives ID control-bubble insertion.
REQ-012 rel_valid  in  NWB  per-channel release strobe (write-back or squash of an issued writer).
REQ-013 rel_rd  in  NWB*RW  channel k index in bits [k*RW +: RW].
REQ-014 busy_vec  out  NREG  bit r = counter r nonzero (registered).
REQ-015 pend_total  out  CNT_W+RW  sum of all counters (registered).
REQ-016 err_underflow  out  1  sticky release-without-writer flag.

Function
REQ-017 Per-register counter cnt[r], CNT_W bits, r = 1..NREG-1; register 0 never tracked, cnt[0] reads 0 always.
REQ-018 Increment: fire & iss_rdwen & iss_rd!=0 adds 1 to cnt[iss_rd] at next edge.
REQ-019 Decrement: each rel_valid[k] with rel_rd!=0 subtracts 1 from cnt[rel_rd[k]]; releases to 0 ignored.
REQ-020 Multiple channels to the same rd in one cycle subtract their count (2 channels -> -2).
REQ-021 Increment and decrement in same cycle combine arithmetically: next = cnt + inc - dec.
REQ-022 If dec > cnt + inc, counter clamps to 0 and err_underflow sets, held until reset.
REQ-023 Source hazard: rsX!=0 & eff[rsX]!=0; eff = cnt - same-cycle releases if WB_BYPASS=1, else cnt.
REQ-024 Capacity hazard: iss_rdwen & iss_rd!=0 & cnt[iss_rd]==CMAX (no bypass credit) stalls.
REQ-025 iss_ready = ~(source hazard rs1 | source hazard rs2 | capacity hazard); purely combinational from state and inputs; independent of iss_valid.
REQ-026 WAW with cnt<CMAX does not stall (in-order release assumed).
REQ-027 rs1==rs2 counts as one dependence; rd==rs1 with busy rs1 stalls on source rule.
REQ-028 Stall latency: iss_ready rises the cycle a final release is presented (WB_BYPASS=1) or the cycle after (WB_BYPASS=0).
REQ-029 busy_vec and pend_total update one edge after fire/release; pend_total never wraps.
REQ-030 No state change while iss_valid=0 except releases.

Reset
REQ-031 rst low asynchronously clears all cnt to 0, busy_vec=0, pend_total=0, err_underflow=0.
REQ-032 During reset iss_ready=1, has_hazard=0; fire/release inputs ignored until first edge after rst deasserts.
REQ-033 Reset mid-stall drops all outstanding writers; no release after reset is required.

Verification
REQ-034 Load-use: issue rd=5 writer; next cycle rs1=5 -> has_hazard=1; rel rd=5 -> iss_ready=1 same cycle (WB_BYPASS=1), busy_vec[5]=0 next edge.
REQ-035 Saturation: CNT_W=2, three writers to rd=7 unreleased -> fourth writer rd=7 stalls; one release -> accepted, cnt[7] stays 3.
REQ-036 Dual release: cnt[3]=2, both channels rel rd=3 same cycle -> cnt[3]=0, pend_total decrements by 2, no error.
REQ-037 Simultaneous: cnt[9]=1, fire writer rd=9 plus rel rd=9 same cycle -> cnt[9]=1, busy_vec[9]=1.
REQ-038 x0/underflow: writer rd=0 -> pend_total unchanged; rel rd=4 with cnt[4]=0 -> err_underflow=1 sticky, cnt[4]=0.
REQ-039 Async reset: cnt[2]=1 and stall pending, drop rst mid-cycle -> iss_ready=1 and busy_vec=0 immediately without a clock edge.

Source files
------------

// File: rtl/ysyx_22050133_id_scoreboard_if.sv
// Issue/release bundle between the ID stage and the register scoreboard.
// Latency: none (wires only).
// Backpressure: iss_ready/has_hazard flow back from the scoreboard to ID.
interface ysyx_22050133_id_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int NWB   = 2
);
  localparam int RW = $clog2(NREG);

  logic                  iss_valid;
  logic [RW-1:0]         iss_rs1;
  logic [RW-1:0]         iss_rs2;
  logic [RW-1:0]         iss_rd;
  logic                  iss_rdwen;
  logic                  iss_ready;
  logic                  has_hazard;
  logic [NWB-1:0]        rel_valid;
  logic [NWB*RW-1:0]     rel_rd;
  logic [NREG-1:0]       busy_vec;
  logic [CNT_W+RW-1:0]   pend_total;
  logic                  err_underflow;

  // ID stage / write-back side
  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rdwen, rel_valid, rel_rd,
    input  iss_ready, has_hazard, busy_vec, pend_total, err_underflow
  );

  // scoreboard side
  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rdwen, rel_valid, rel_rd,
    output iss_ready, has_hazard, busy_vec, pend_total, err_underflow
  );
endinterface

// File: rtl/ysyx_22050133_id_scoreboard.sv
// Per-register outstanding-writer scoreboard gating instruction issue at ID.
// Latency: iss_ready combinational; busy_vec/pend_total/err_underflow one edge after fire/release.
// Backpressure: iss_ready drops on a RAW source hazard or when the rd counter is saturated.
module ysyx_22050133_id_scoreboard #(
  parameter int NREG      = 32,
  parameter int CNT_W     = 2,
  parameter int NWB       = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22050133_id_scoreboard_if.slave  sb
);
  localparam int RW    = $clog2(NREG);
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int DEC_W = $clog2(NWB + 1);
  // wide enough for cnt + inc and for the release count without wrapping
  localparam int SUM_W = CNT_W + DEC_W + 1;
  localparam int PT_W  = CNT_W + RW;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [DEC_W-1:0] dec   [NREG];
  logic [NREG-1:0]  pend_eff;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [PT_W-1:0]  pend_q, pend_d;
  logic             err_q, err_d;
  logic             haz_rs1, haz_rs2, haz_cap;
  logic             iss_ready;
  logic             fire;
  logic             uf;
  logic             inc_v;
  logic [SUM_W-1:0] sum_v;

  // count same-cycle releases per register; releases of x0 are dropped
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      dec[r] = '0;
      for (int k = 0; k < NWB; k++) begin
        if (sb.rel_valid[k] && (r != 0) && (sb.rel_rd[k*RW +: RW] == RW'(r))) begin
          dec[r] = dec[r] + DEC_W'(1);
        end
      end
    end
  end

  // hazard detection: sources may see release credit, capacity never does
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if (WB_BYPASS != 0) begin
        pend_eff[r] = SUM_W'(cnt_q[r]) > SUM_W'(dec[r]);
      end else begin
        pend_eff[r] = cnt_q[r] != '0;
      end
    end
    haz_rs1   = (sb.iss_rs1 != '0) && pend_eff[sb.iss_rs1];
    haz_rs2   = (sb.iss_rs2 != '0) && pend_eff[sb.iss_rs2];
    haz_cap   = sb.iss_rdwen && (sb.iss_rd != '0) && (cnt_q[sb.iss_rd] == CNT_W'(CMAX));
    iss_ready = ~(haz_rs1 | haz_rs2 | haz_cap);
    fire      = sb.iss_valid & iss_ready;
  end

  // next counter values: cnt + inc - dec, clamping at zero and flagging underflow
  always_comb begin
    uf     = 1'b0;
    inc_v  = 1'b0;
    sum_v  = '0;
    pend_d = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_v = fire && sb.iss_rdwen && (r != 0) && (sb.iss_rd == RW'(r));
      sum_v = SUM_W'(cnt_q[r]) + SUM_W'(inc_v);
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (SUM_W'(dec[r]) > sum_v) begin
        cnt_d[r] = '0;
        uf       = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(sum_v - SUM_W'(dec[r]));
      end
      busy_d[r] = cnt_d[r] != '0;
      pend_d    = pend_d + PT_W'(cnt_d[r]);
    end
    err_d = err_q | uf;
  end

  // state registers; reset drops every outstanding writer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign sb.iss_ready     = iss_ready;
  assign sb.has_hazard    = sb.iss_valid & ~iss_ready;
  assign sb.busy_vec      = busy_q;
  assign sb.pend_total    = pend_q;
  assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_ysyx_22050133_id_scoreboard.sv
// Directed bench for the ID scoreboard: load-use, saturation, dual release,
// simultaneous inc/dec, x0 handling, underflow and asynchronous reset.
// Inputs driven 1 time unit after the rising edge, outputs sampled after settling.
module tb_ysyx_22050133_id_scoreboard;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  ysyx_22050133_id_scoreboard_if #(.NREG(32), .CNT_W(2), .NWB(2)) u_if ();

  ysyx_22050133_id_scoreboard #(
    .NREG(32), .CNT_W(2), .NWB(2), .WB_BYPASS(1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .sb  (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wen);
    u_if.iss_valid = v;
    u_if.iss_rs1   = rs1;
    u_if.iss_rs2   = rs2;
    u_if.iss_rd    = rd;
    u_if.iss_rdwen = wen;
  endtask

  task automatic drive_rel(input logic v0, input logic [4:0] r0,
                           input logic v1, input logic [4:0] r1);
    u_if.rel_valid = {v1, v0};
    u_if.rel_rd    = {r1, r0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    // activity during reset must be ignored
    drive_iss(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    drive_rel(1'b1, 5'd4, 1'b0, 5'd0);
    #3;
    check("rst_ready",   32'(u_if.iss_ready),     32'd1);
    check("rst_hazard",  32'(u_if.has_hazard),    32'd0);
    check("rst_busy",    32'(u_if.busy_vec),      32'd0);
    check("rst_pend",    32'(u_if.pend_total),    32'd0);
    check("rst_err",     32'(u_if.err_underflow), 32'd0);
    #8;
    drive_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    drive_rel(1'b0, 5'd0, 1'b0, 5'd0);
    #1 rst = 1'b1;
    tick;
    check("post_rst_err",  32'(u_if.err_underflow), 32'd0);
    check("post_rst_pend", 32'(u_if.pend_total),    32'd0);

    // load-use on x5 with write-back bypass
    drive_iss(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    settle;
    check("lu_wr_ready", 32'(u_if.iss_ready), 32'd1);
    tick;
    check("lu_busy5", 32'(u_if.busy_vec),   32'h0000_0020);
    check("lu_pend1", 32'(u_if.pend_total), 32'd1);
    drive_iss(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    settle;
    check("lu_hazard", 32'(u_if.has_hazard), 32'd1);
    check("lu_stall",  32'(u_if.iss_ready),  32'd0);
    drive_rel(1'b1, 5'd5, 1'b0, 5'd0);
    settle;
    check("lu_bypass_ready",  32'(u_if.iss_ready),  32'd1);
    check("lu_bypass_hazard", 32'(u_if.has_hazard), 32'd0);
    tick;
    drive_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    drive_rel(1'b0, 5'd0, 1'b0, 5'd0);
    settle;
    check("lu_busy_clr", 32'(u_if.busy_vec),      32'd0);
    check("lu_pend0",    32'(u_if.pend_total),    32'd0);
    check("lu_err",      32'(u_if.err_underflow), 32'd0);

    // saturation on x7
    drive_iss(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    tick;
    tick;
    tick;
    check("sat_pend3", 32'(u_if.pend_total), 32'd3);
    check("sat_busy7", 32'(u_if.busy_vec),   32'h0000_0080);
    check("sat_stall", 32'(u_if.iss_ready),  32'd0);
    check("sat_hazard", 32'(u_if.has_hazard), 32'd1);
    tick;
    check("sat_hold", 32'(u_if.pend_total), 32'd3);
    drive_rel(1'b1, 5'd7, 1'b0, 5'd0);
    settle;
    check("sat_no_credit", 32'(u_if.iss_ready), 32'd0);
    tick;
    drive_rel(1'b0, 5'd0, 1'b0, 5'd0);
    settle;
    check("sat_pend2",  32'(u_if.pend_total), 32'd2);
    check("sat_ready",  32'(u_if.iss_ready),  32'd1);
    tick;
    drive_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("sat_accept", 32'(u_if.pend_total), 32'd3);
    drive_rel(1'b1, 5'd7, 1'b1, 5'd7);
    tick;
    drive_rel(1'b1, 5'd7, 1'b0, 5'd0);
    tick;
    drive_rel(1'b0, 5'd0, 1'b0, 5'd0);
    settle;
    check("sat_drain", 32'(u_if.pend_total),    32'd0);
    check("sat_err",   32'(u_if.err_underflow), 32'd0);

    // dual release of x3
    drive_iss(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    tick;
    tick;
    drive_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("dual_pend2", 32'(u_if.pend_total), 32'd2);
    drive_rel(1'b1, 5'd3, 1'b1, 5'd3);
    tick;
    drive_rel(1'b0, 5'd0, 1'b0, 5'd0);
    check("dual_pend0", 32'(u_if.pend_total),    32'd0);
    check("dual_busy",  32'(u_if.busy_vec),      32'd0);
    check("dual_err",   32'(u_if.err_underflow), 32'd0);

    // simultaneous writer and release on x9
    drive_iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    tick;
    drive_rel(1'b0, 5'd0, 1'b1, 5'd9);
    settle;
    check("sim_ready", 32'(u_if.iss_ready), 32'd1);
    tick;
    drive_rel(1'b0, 5'd0, 1'b0, 5'd0);
    drive_iss(1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    settle;
    check("sim_busy9",  32'(u_if.busy_vec),   32'h0000_0200);
    check("sim_pend1",  32'(u_if.pend_total), 32'd1);
    check("sim_hazard", 32'(u_if.has_hazard), 32'd1);
    drive_rel(1'b0, 5'd0, 1'b1, 5'd9);
    settle;
    check("sim_ch1_bypass", 32'(u_if.iss_ready), 32'd1);
    tick;
    drive_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    drive_rel(1'b0, 5'd0, 1'b0, 5'd0);
    check("sim_pend0", 32'(u_if.pend_total), 32'd0);

    // x0 writer, idle issue, x0 release, then underflow on x4
    drive_iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    tick;
    drive_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("x0_pend", 32'(u_if.pend_total), 32'd0);
    check("x0_busy", 32'(u_if.busy_vec),   32'd0);
    drive_iss(1'b0, 5'd0, 5'd0, 5'd6, 1'b1);
    tick;
    drive_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("novalid_pend", 32'(u_if.pend_total), 32'd0);
    drive_rel(1'b1, 5'd0, 1'b0, 5'd0);
    tick;
    check("x0_rel_err", 32'(u_if.err_underflow), 32'd0);
    drive_rel(1'b1, 5'd4, 1'b0, 5'd0);
    tick;
    drive_rel(1'b0, 5'd0, 1'b0, 5'd0);
    check("uf_err",  32'(u_if.err_underflow), 32'd1);
    check("uf_pend", 32'(u_if.pend_total),    32'd0);
    check("uf_busy", 32'(u_if.busy_vec),      32'd0);
    tick;
    check("uf_sticky", 32'(u_if.err_underflow), 32'd1);

    // asynchronous reset in the middle of a stall on x2
    drive_iss(1'b1, 5'd0, 5'd0, 5'd2, 1'b1);
    tick;
    drive_iss(1'b1, 5'd2, 5'd0, 5'd0, 1'b0);
    settle;
    check("ar_busy2",  32'(u_if.busy_vec),   32'h0000_0004);
    check("ar_hazard", 32'(u_if.has_hazard), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_ready",  32'(u_if.iss_ready),     32'd1);
    check("ar_nohaz",  32'(u_if.has_hazard),    32'd0);
    check("ar_busy0",  32'(u_if.busy_vec),      32'd0);
    check("ar_pend0",  32'(u_if.pend_total),    32'd0);
    check("ar_errclr", 32'(u_if.err_underflow), 32'd0);
    drive_iss(1'b1, 5'd0, 5'd0, 5'd8, 1'b1);
    drive_rel(1'b1, 5'd2, 1'b0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    drive_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    drive_rel(1'b0, 5'd0, 1'b0, 5'd0);
    rst = 1'b1;
    tick;
    check("ar_after_busy", 32'(u_if.busy_vec),      32'd0);
    check("ar_after_pend", 32'(u_if.pend_total),    32'd0);
    check("ar_after_err",  32'(u_if.err_underflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
